ofs_plat_ccip_axi_mem_bridge: RTL and testbench
===============================================

// Module: ofs_plat_ccip_axi_mem_bridge
//
// PURPOSE
//  Terminal AXI-to-CCI-P translator for host memory, sitting below the burst mapper in the FIU clock domain.
//  Maps legal CCI-P-sized, naturally aligned AXI bursts 1:1 onto CCI-P c0 reads and c1 writes/fences.
//  Carries AXI IDs and burst lengths through CCI-P mdata, and regenerates RLAST/B from FIU responses.
//  Successor to the stubbed fixed-width mapper: parametrised ID/width/burst, multi-line write FSM, fence support.
//
// PARAMETERS
//  ADDR_WIDTH       42   line (64B) address width
//  DATA_WIDTH       512  line data width
//  ID_WIDTH         8    AXI ID width; must be <= 12 (elaboration $error otherwise)
//  MAX_BURST_LINES  4    1, 2 or 4; larger AXI len is illegal (sim $fatal)
//
// PORTS
//  clk           in   1       clock
//  reset_n       in   1       synchronous, active-low reset
//  arvalid/arready in/out 1   AXI read address handshake
//  arid          in   ID_WIDTH    read ID
//  araddr        in   ADDR_WIDTH  line address
//  arlen         in   2       lines-1
//  rvalid        out  1       read data beat
//  rready        in   1       must be 1 whenever rvalid (sim $fatal); no backpressure
//  rid/rdata/rlast out ID_WIDTH/DATA_WIDTH/1  read beat payload
//  awvalid/awready in/out 1   AXI write address handshake
//  awid/awaddr/awlen in  ID_WIDTH/ADDR_WIDTH/2  write command
//  awfence       in   1       write fence (no W beats)
//  aw_expects_rsp in  1       generate B for this burst
//  wvalid/wready in/out 1     AXI write data handshake
//  wdata/wlast   in   DATA_WIDTH/1  write beat
//  bvalid/bid    out  1/ID_WIDTH    write response; no backpressure
//  c0_almfull, c1_almfull in 1      FIU TX almost-full
//  c0tx_valid/addr/cl_len/mdata out 1/ADDR_WIDTH/2/16  CCI-P RdLine_I request
//  c0rx_valid/data/mdata/cl_num in 1/DATA_WIDTH/16/2   in-order read response
//  c1tx_valid/addr/cl_len/sop/fence/mdata/data out     CCI-P WrLine_I / WrFence
//  c1rx_valid/mdata in 1/16   write or fence response (packed)
//
// BEHAVIOUR
//  mdata layout: [1:0]=cl_len, [2]=expects_rsp, [3+:ID_WIDTH]=id, rest 0.
//  arready <= !c0_almfull; awready, wready <= !c1_almfull (registered, 1-cycle lag; almfull slack covers it).
//  Read: AR fire -> c0tx_valid next cycle, addr=araddr, cl_len=arlen, mdata={id,0,arlen}.
//  Read rsp: c0rx_valid -> rvalid next cycle; rid=mdata id; rlast=(cl_num==mdata[1:0]).
//  Write FSM: SOP, BODY.
//   SOP: write fires when awvalid&&awready&&wvalid&&wready (&&!awfence); AW consumed, beat 0 sent, sop=1, cl_len=awlen.
//        If awlen==0 stay SOP, else latch base/len/mdata, cnt=1 -> BODY.
//        Fence fires on awvalid&&awready&&awfence without W; c1tx fence=1, addr=0, sop=1.
//   BODY: each W fire -> c1tx beat, sop=0, addr=base|cnt on [1:0]; cnt==len -> SOP, else cnt++.
//   In BODY, awready forced 0; in SOP, wready forced 0 unless awvalid&&!awfence.
//  wlast must equal (beat==len) (sim $fatal); addr low bits must be aligned to len+1 (sim $fatal).
//  c1tx registered: 1-cycle latency from fire.
//  B: c1rx_valid && mdata[2] -> bvalid next cycle, bid=mdata id; mdata[2]==0 suppressed.
//  Simultaneous read and write traffic is independent; c0 and c1 rsp same cycle both forwarded.
//  Reset: all valids/readies 0, FSM=SOP, cnt=0; mid-burst reset abandons the burst, no partial replay.
//
// STRUCTURE
//  ofs_plat_ccip_axi_bridge_pkg: mdata field offsets, t_wr_state enum, mdata pack/unpack functions.
//  Sub-module ofs_plat_ccip_axi_bridge_wr_fsm: SOP/BODY FSM and c1tx generation; read path stays inline.
//
// TESTING
//  AR id=5 addr=0x100 len=3 -> c0tx cl_len=3 mdata=0x2B; 4 rsp cl_num 0..3 -> rid=5, rlast only on beat 3.
//  AW id=9 addr=0x204 len=3 exp=1 + 4 W -> c1tx addrs 0x204..0x207, sop 1,0,0,0; rsp -> bvalid bid=9.
//  AW len=1 exp=0 -> 2 c1tx beats; c1rx -> no bvalid.
//  awfence id=3 exp=1 with wvalid low -> single c1tx fence=1 sop=1; fence rsp -> bid=3.
//  c1_almfull=1 mid-BODY -> wready 0 next cycle, beats resume from correct cnt after release.
//  reset_n=0 after 2 of 4 beats -> valids 0, FSM SOP; next AW len=0 completes normally.

Source files
------------

// File: rtl/ofs_plat_ccip_axi_bridge_pkg.sv
// Shared definitions for the AXI to CCI-P host memory bridge.
// The CCI-P mdata field carries the AXI ID, the response request flag and the
// burst length, so each response can be routed back without local tracking state.
package ofs_plat_ccip_axi_bridge_pkg;

    localparam int MDATA_WIDTH   = 16;
    localparam int MDATA_LEN_LSB = 0;
    localparam int MDATA_RSP_BIT = 2;
    localparam int MDATA_ID_LSB  = 3;
    localparam int MDATA_ID_MAX  = 12;

    typedef enum logic [0:0] {
        WR_SOP  = 1'b0,
        WR_BODY = 1'b1
    } t_wr_state;

    // Build an mdata word. Any bits above the ID field are always zero.
    function automatic logic [MDATA_WIDTH-1:0] mdata_pack(
        input logic [MDATA_ID_MAX-1:0] id,
        input logic                    expects_rsp,
        input logic [1:0]              cl_len
    );
        logic [MDATA_WIDTH-1:0] m;
        m = '0;
        m[MDATA_LEN_LSB +: 2]            = cl_len;
        m[MDATA_RSP_BIT]                 = expects_rsp;
        m[MDATA_ID_LSB +: MDATA_ID_MAX]  = id;
        return m;
    endfunction

    function automatic logic [MDATA_ID_MAX-1:0] mdata_id(input logic [MDATA_WIDTH-1:0] m);
        return m[MDATA_ID_LSB +: MDATA_ID_MAX];
    endfunction

    function automatic logic mdata_expects_rsp(input logic [MDATA_WIDTH-1:0] m);
        return m[MDATA_RSP_BIT];
    endfunction

    function automatic logic [1:0] mdata_cl_len(input logic [MDATA_WIDTH-1:0] m);
        return m[MDATA_LEN_LSB +: 2];
    endfunction

endpackage

// File: rtl/ofs_plat_ccip_axi_bridge_wr_fsm.sv
// Write side of the bridge: turns an AXI AW plus its W beats into a sequence
// of CCI-P c1 WrLine_I beats, and a fenced AW into a single WrFence.
// The first beat travels with the AW; the remaining beats reuse the latched
// base address, length and mdata.
module ofs_plat_ccip_axi_bridge_wr_fsm #(
    parameter int ADDR_WIDTH      = 42,
    parameter int DATA_WIDTH      = 512,
    parameter int ID_WIDTH        = 8,
    parameter int MAX_BURST_LINES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  c1_almfull,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ID_WIDTH-1:0]   awid,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [1:0]            awlen,
    input  logic                  awfence,
    input  logic                  aw_expects_rsp,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wlast,
    output logic                  c1tx_valid,
    output logic [ADDR_WIDTH-1:0] c1tx_addr,
    output logic [1:0]            c1tx_cl_len,
    output logic                  c1tx_sop,
    output logic                  c1tx_fence,
    output logic [15:0]           c1tx_mdata,
    output logic [DATA_WIDTH-1:0] c1tx_data
);
    import ofs_plat_ccip_axi_bridge_pkg::*;

    t_wr_state             state, state_next;
    logic [1:0]            cnt, cnt_next;
    logic [1:0]            len, len_next;
    logic [ADDR_WIDTH-1:0] base, base_next;
    logic [15:0]           mdata, mdata_next;
    logic                  rdy;

    logic                  tx_valid_next;
    logic [ADDR_WIDTH-1:0] tx_addr_next;
    logic [1:0]            tx_len_next;
    logic                  tx_sop_next;
    logic                  tx_fence_next;
    logic [15:0]           tx_mdata_next;
    logic [DATA_WIDTH-1:0] tx_data_next;

    logic aw_wr_fire;
    logic aw_fence_fire;
    logic body_fire;

    // Registered view of the FIU almost-full; its slack absorbs the one-cycle lag.
    always_ff @(posedge clk) begin
        if (!reset_n) rdy <= 1'b0;
        else          rdy <= !c1_almfull;
    end

    assign awready = rdy && (state == WR_SOP);
    assign wready  = rdy && ((state == WR_BODY) || (awvalid && !awfence));

    assign aw_wr_fire    = (state == WR_SOP) && awvalid && awready && !awfence && wvalid && wready;
    assign aw_fence_fire = (state == WR_SOP) && awvalid && awready && awfence;
    assign body_fire     = (state == WR_BODY) && wvalid && wready;

    // Next-state and next c1tx beat selection.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        len_next      = len;
        base_next     = base;
        mdata_next    = mdata;
        tx_valid_next = 1'b0;
        tx_addr_next  = '0;
        tx_len_next   = 2'd0;
        tx_sop_next   = 1'b0;
        tx_fence_next = 1'b0;
        tx_mdata_next = '0;
        tx_data_next  = '0;

        case (state)
            WR_SOP: begin
                if (aw_wr_fire) begin
                    tx_valid_next = 1'b1;
                    tx_addr_next  = awaddr;
                    tx_len_next   = awlen;
                    tx_sop_next   = 1'b1;
                    tx_mdata_next = mdata_pack(MDATA_ID_MAX'(awid), aw_expects_rsp, awlen);
                    tx_data_next  = wdata;
                    if (awlen != 2'd0) begin
                        state_next = WR_BODY;
                        base_next  = awaddr;
                        len_next   = awlen;
                        mdata_next = tx_mdata_next;
                        cnt_next   = 2'd1;
                    end
                end else if (aw_fence_fire) begin
                    tx_valid_next = 1'b1;
                    tx_sop_next   = 1'b1;
                    tx_fence_next = 1'b1;
                    tx_mdata_next = mdata_pack(MDATA_ID_MAX'(awid), aw_expects_rsp, 2'd0);
                end
            end
            WR_BODY: begin
                if (body_fire) begin
                    tx_valid_next = 1'b1;
                    tx_addr_next  = {base[ADDR_WIDTH-1:2], cnt};
                    tx_len_next   = len;
                    tx_mdata_next = mdata;
                    tx_data_next  = wdata;
                    if (cnt == len) begin
                        state_next = WR_SOP;
                        cnt_next   = 2'd0;
                    end else begin
                        cnt_next = cnt + 2'd1;
                    end
                end
            end
            default: state_next = WR_SOP;
        endcase
    end

    // State, burst context and the registered c1tx channel.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= WR_SOP;
            cnt         <= 2'd0;
            len         <= 2'd0;
            base        <= '0;
            mdata       <= '0;
            c1tx_valid  <= 1'b0;
            c1tx_addr   <= '0;
            c1tx_cl_len <= 2'd0;
            c1tx_sop    <= 1'b0;
            c1tx_fence  <= 1'b0;
            c1tx_mdata  <= '0;
            c1tx_data   <= '0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            len         <= len_next;
            base        <= base_next;
            mdata       <= mdata_next;
            c1tx_valid  <= tx_valid_next;
            c1tx_addr   <= tx_addr_next;
            c1tx_cl_len <= tx_len_next;
            c1tx_sop    <= tx_sop_next;
            c1tx_fence  <= tx_fence_next;
            c1tx_mdata  <= tx_mdata_next;
            c1tx_data   <= tx_data_next;
        end
    end

    // Simulation guards on burst legality: length, alignment and wlast placement.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (aw_wr_fire) begin
                assert (awlen != 2'd2 && int'(awlen) < MAX_BURST_LINES &&
                        (awaddr[1:0] & awlen) == 2'b00)
                    else $fatal(1, "illegal AXI write burst length or alignment");
                assert (wlast == (awlen == 2'd0))
                    else $fatal(1, "wlast misplaced on first write beat");
            end
            if (body_fire) begin
                assert (wlast == (cnt == len))
                    else $fatal(1, "wlast misplaced within write burst");
            end
        end
    end

endmodule

// File: rtl/ofs_plat_ccip_axi_mem_bridge.sv
// Terminal AXI to CCI-P bridge for host memory in the FIU clock domain.
// Reads map 1:1 onto c0 RdLine_I, writes and fences onto c1 via the write FSM.
// Responses are routed back purely from the mdata they return with.
module ofs_plat_ccip_axi_mem_bridge #(
    parameter int ADDR_WIDTH      = 42,
    parameter int DATA_WIDTH      = 512,
    parameter int ID_WIDTH        = 8,
    parameter int MAX_BURST_LINES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [1:0]            arlen,

    output logic                  rvalid,
    input  logic                  rready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rlast,

    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ID_WIDTH-1:0]   awid,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [1:0]            awlen,
    input  logic                  awfence,
    input  logic                  aw_expects_rsp,

    input  logic                  wvalid,
    output logic                  wready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wlast,

    output logic                  bvalid,
    output logic [ID_WIDTH-1:0]   bid,

    input  logic                  c0_almfull,
    input  logic                  c1_almfull,

    output logic                  c0tx_valid,
    output logic [ADDR_WIDTH-1:0] c0tx_addr,
    output logic [1:0]            c0tx_cl_len,
    output logic [15:0]           c0tx_mdata,

    input  logic                  c0rx_valid,
    input  logic [DATA_WIDTH-1:0] c0rx_data,
    input  logic [15:0]           c0rx_mdata,
    input  logic [1:0]            c0rx_cl_num,

    output logic                  c1tx_valid,
    output logic [ADDR_WIDTH-1:0] c1tx_addr,
    output logic [1:0]            c1tx_cl_len,
    output logic                  c1tx_sop,
    output logic                  c1tx_fence,
    output logic [15:0]           c1tx_mdata,
    output logic [DATA_WIDTH-1:0] c1tx_data,

    input  logic                  c1rx_valid,
    input  logic [15:0]           c1rx_mdata
);
    import ofs_plat_ccip_axi_bridge_pkg::*;

    if (ID_WIDTH < 1 || ID_WIDTH > MDATA_ID_MAX) begin : g_bad_id_width
        $error("ID_WIDTH must be between 1 and 12 to fit in mdata");
    end
    if (MAX_BURST_LINES != 1 && MAX_BURST_LINES != 2 && MAX_BURST_LINES != 4) begin : g_bad_burst
        $error("MAX_BURST_LINES must be 1, 2 or 4");
    end

    logic                    ar_fire;
    logic [MDATA_ID_MAX-1:0] rd_rsp_id;
    logic [MDATA_ID_MAX-1:0] wr_rsp_id;
    logic                    unused_ok;

    assign ar_fire   = arvalid && arready;
    assign rd_rsp_id = mdata_id(c0rx_mdata);
    assign wr_rsp_id = mdata_id(c1rx_mdata);
    assign unused_ok = ^{rd_rsp_id, wr_rsp_id, c0rx_mdata, c1rx_mdata, rready};

    // Read address acceptance follows c0 almost-full with one cycle of lag.
    always_ff @(posedge clk) begin
        if (!reset_n) arready <= 1'b0;
        else          arready <= !c0_almfull;
    end

    // Each accepted AR becomes one c0 request carrying ID and length in mdata.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            c0tx_valid  <= 1'b0;
            c0tx_addr   <= '0;
            c0tx_cl_len <= 2'd0;
            c0tx_mdata  <= '0;
        end else begin
            c0tx_valid <= ar_fire;
            if (ar_fire) begin
                c0tx_addr   <= araddr;
                c0tx_cl_len <= arlen;
                c0tx_mdata  <= mdata_pack(MDATA_ID_MAX'(arid), 1'b0, arlen);
            end
        end
    end

    // Read responses become R beats; the last line of the burst carries rlast.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rvalid <= 1'b0;
            rid    <= '0;
            rdata  <= '0;
            rlast  <= 1'b0;
        end else begin
            rvalid <= c0rx_valid;
            if (c0rx_valid) begin
                rid   <= rd_rsp_id[ID_WIDTH-1:0];
                rdata <= c0rx_data;
                rlast <= (c0rx_cl_num == mdata_cl_len(c0rx_mdata));
            end
        end
    end

    // Write and fence responses become B only when the burst asked for one.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bvalid <= 1'b0;
            bid    <= '0;
        end else begin
            bvalid <= c1rx_valid && mdata_expects_rsp(c1rx_mdata);
            if (c1rx_valid) bid <= wr_rsp_id[ID_WIDTH-1:0];
        end
    end

    // Simulation guards: R has no backpressure and read bursts must be legal.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (rvalid) begin
                assert (rready) else $fatal(1, "rready low while rvalid");
            end
            if (ar_fire) begin
                assert (arlen != 2'd2 && int'(arlen) < MAX_BURST_LINES &&
                        (araddr[1:0] & arlen) == 2'b00)
                    else $fatal(1, "illegal AXI read burst length or alignment");
            end
        end
    end

    ofs_plat_ccip_axi_bridge_wr_fsm #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .DATA_WIDTH      (DATA_WIDTH),
        .ID_WIDTH        (ID_WIDTH),
        .MAX_BURST_LINES (MAX_BURST_LINES)
    ) wr_fsm (
        .clk            (clk),
        .reset_n        (reset_n),
        .c1_almfull     (c1_almfull),
        .awvalid        (awvalid),
        .awready        (awready),
        .awid           (awid),
        .awaddr         (awaddr),
        .awlen          (awlen),
        .awfence        (awfence),
        .aw_expects_rsp (aw_expects_rsp),
        .wvalid         (wvalid),
        .wready         (wready),
        .wdata          (wdata),
        .wlast          (wlast),
        .c1tx_valid     (c1tx_valid),
        .c1tx_addr      (c1tx_addr),
        .c1tx_cl_len    (c1tx_cl_len),
        .c1tx_sop       (c1tx_sop),
        .c1tx_fence     (c1tx_fence),
        .c1tx_mdata     (c1tx_mdata),
        .c1tx_data      (c1tx_data)
    );

endmodule

// File: tb/tb_ofs_plat_ccip_axi_mem_bridge.sv
// Directed bench for the AXI to CCI-P host memory bridge.
// Expected values are hand-computed from the mdata layout:
// {id, expects_rsp, cl_len} packed at bits [3+], [2], [1:0].
module tb_ofs_plat_ccip_axi_mem_bridge;

    localparam int ADDR_WIDTH = 42;
    localparam int DATA_WIDTH = 512;
    localparam int ID_WIDTH   = 8;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [1:0]            arlen;
    logic                  rvalid;
    logic                  rready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rlast;
    logic                  awvalid;
    logic                  awready;
    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [1:0]            awlen;
    logic                  awfence;
    logic                  aw_expects_rsp;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wlast;
    logic                  bvalid;
    logic [ID_WIDTH-1:0]   bid;
    logic                  c0_almfull;
    logic                  c1_almfull;
    logic                  c0tx_valid;
    logic [ADDR_WIDTH-1:0] c0tx_addr;
    logic [1:0]            c0tx_cl_len;
    logic [15:0]           c0tx_mdata;
    logic                  c0rx_valid;
    logic [DATA_WIDTH-1:0] c0rx_data;
    logic [15:0]           c0rx_mdata;
    logic [1:0]            c0rx_cl_num;
    logic                  c1tx_valid;
    logic [ADDR_WIDTH-1:0] c1tx_addr;
    logic [1:0]            c1tx_cl_len;
    logic                  c1tx_sop;
    logic                  c1tx_fence;
    logic [15:0]           c1tx_mdata;
    logic [DATA_WIDTH-1:0] c1tx_data;
    logic                  c1rx_valid;
    logic [15:0]           c1rx_mdata;

    int vector_count    = 0;
    int miscompare_count = 0;

    ofs_plat_ccip_axi_mem_bridge #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .DATA_WIDTH      (DATA_WIDTH),
        .ID_WIDTH        (ID_WIDTH),
        .MAX_BURST_LINES (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .arvalid        (arvalid),
        .arready        (arready),
        .arid           (arid),
        .araddr         (araddr),
        .arlen          (arlen),
        .rvalid         (rvalid),
        .rready         (rready),
        .rid            (rid),
        .rdata          (rdata),
        .rlast          (rlast),
        .awvalid        (awvalid),
        .awready        (awready),
        .awid           (awid),
        .awaddr         (awaddr),
        .awlen          (awlen),
        .awfence        (awfence),
        .aw_expects_rsp (aw_expects_rsp),
        .wvalid         (wvalid),
        .wready         (wready),
        .wdata          (wdata),
        .wlast          (wlast),
        .bvalid         (bvalid),
        .bid            (bid),
        .c0_almfull     (c0_almfull),
        .c1_almfull     (c1_almfull),
        .c0tx_valid     (c0tx_valid),
        .c0tx_addr      (c0tx_addr),
        .c0tx_cl_len    (c0tx_cl_len),
        .c0tx_mdata     (c0tx_mdata),
        .c0rx_valid     (c0rx_valid),
        .c0rx_data      (c0rx_data),
        .c0rx_mdata     (c0rx_mdata),
        .c0rx_cl_num    (c0rx_cl_num),
        .c1tx_valid     (c1tx_valid),
        .c1tx_addr      (c1tx_addr),
        .c1tx_cl_len    (c1tx_cl_len),
        .c1tx_sop       (c1tx_sop),
        .c1tx_fence     (c1tx_fence),
        .c1tx_mdata     (c1tx_mdata),
        .c1tx_data      (c1tx_data),
        .c1rx_valid     (c1rx_valid),
        .c1rx_mdata     (c1rx_mdata)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vector_count++;
        if (got !== exp) begin
            miscompare_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idleInputs();
        arvalid        = 1'b0;
        arid           = '0;
        araddr         = '0;
        arlen          = 2'd0;
        rready         = 1'b1;
        awvalid        = 1'b0;
        awid           = '0;
        awaddr         = '0;
        awlen          = 2'd0;
        awfence        = 1'b0;
        aw_expects_rsp = 1'b0;
        wvalid         = 1'b0;
        wdata          = '0;
        wlast          = 1'b0;
        c0_almfull     = 1'b0;
        c1_almfull     = 1'b0;
        c0rx_valid     = 1'b0;
        c0rx_data      = '0;
        c0rx_mdata     = '0;
        c0rx_cl_num    = 2'd0;
        c1rx_valid     = 1'b0;
        c1rx_mdata     = '0;
    endtask

    // Drive one write beat, optionally with its AW, and check the resulting c1tx beat.
    task automatic writeBeat(input string tag, input logic [63:0] data, input logic last,
                             input logic [63:0] exp_addr, input logic exp_sop,
                             input logic [63:0] exp_mdata);
        wvalid = 1'b1;
        wdata  = DATA_WIDTH'(data);
        wlast  = last;
        applyStimulus();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        checkOutput({tag, "_valid"}, 64'(c1tx_valid), 64'd1);
        checkOutput({tag, "_addr"},  64'(c1tx_addr), exp_addr);
        checkOutput({tag, "_sop"},   64'(c1tx_sop), 64'(exp_sop));
        checkOutput({tag, "_mdata"}, 64'(c1tx_mdata), exp_mdata);
        checkOutput({tag, "_data"},  c1tx_data[63:0], data);
    endtask

    initial begin
        idleInputs();
        reset_n = 1'b0;
        repeat (3) applyStimulus();

        // Reset state
        checkOutput("rst_arready", 64'(arready), 64'd0);
        checkOutput("rst_awready", 64'(awready), 64'd0);
        checkOutput("rst_c0tx",    64'(c0tx_valid), 64'd0);
        checkOutput("rst_c1tx",    64'(c1tx_valid), 64'd0);
        checkOutput("rst_rvalid",  64'(rvalid), 64'd0);
        checkOutput("rst_bvalid",  64'(bvalid), 64'd0);

        reset_n = 1'b1;
        applyStimulus();
        checkOutput("arready_up", 64'(arready), 64'd1);
        checkOutput("awready_up", 64'(awready), 64'd1);

        // Read: id 5, 4 lines at 0x100 -> mdata = 5<<3 | 3 = 0x2B
        arvalid = 1'b1;
        arid    = 8'd5;
        araddr  = 42'h100;
        arlen   = 2'd3;
        applyStimulus();
        arvalid = 1'b0;
        checkOutput("c0tx_valid", 64'(c0tx_valid), 64'd1);
        checkOutput("c0tx_addr",  64'(c0tx_addr), 64'h100);
        checkOutput("c0tx_len",   64'(c0tx_cl_len), 64'd3);
        checkOutput("c0tx_mdata", 64'(c0tx_mdata), 64'h2B);
        applyStimulus();
        checkOutput("c0tx_idle", 64'(c0tx_valid), 64'd0);

        for (int i = 0; i < 4; i++) begin
            c0rx_valid  = 1'b1;
            c0rx_mdata  = 16'h002B;
            c0rx_cl_num = 2'(i);
            c0rx_data   = DATA_WIDTH'(64'hA0 + 64'(i));
            applyStimulus();
            checkOutput("r_valid", 64'(rvalid), 64'd1);
            checkOutput("r_id",    64'(rid), 64'd5);
            checkOutput("r_last",  64'(rlast), (i == 3) ? 64'd1 : 64'd0);
            checkOutput("r_data",  rdata[63:0], 64'hA0 + 64'(i));
        end
        c0rx_valid = 1'b0;
        applyStimulus();
        checkOutput("r_idle", 64'(rvalid), 64'd0);

        // Write: id 9, 4 lines at 0x204, B wanted -> mdata = 0x48 | 4 | 3 = 0x4F
        awvalid        = 1'b1;
        awid           = 8'd9;
        awaddr         = 42'h204;
        awlen          = 2'd3;
        aw_expects_rsp = 1'b1;
        #1;
        checkOutput("sop_wready", 64'(wready), 64'd1);
        writeBeat("wr0", 64'hD0, 1'b0, 64'h204, 1'b1, 64'h4F);
        checkOutput("wr0_len",       64'(c1tx_cl_len), 64'd3);
        checkOutput("body_awready",  64'(awready), 64'd0);
        writeBeat("wr1", 64'hD1, 1'b0, 64'h205, 1'b0, 64'h4F);

        // Almost-full lands mid-burst: this beat still goes (registered lag)
        c1_almfull = 1'b1;
        writeBeat("wr2", 64'hD2, 1'b0, 64'h206, 1'b0, 64'h4F);
        checkOutput("af_wready", 64'(wready), 64'd0);
        wvalid = 1'b1;
        wdata  = DATA_WIDTH'(64'hD3);
        wlast  = 1'b1;
        applyStimulus();
        checkOutput("af_stall", 64'(c1tx_valid), 64'd0);
        c1_almfull = 1'b0;
        applyStimulus();
        checkOutput("af_still_stall", 64'(c1tx_valid), 64'd0);
        checkOutput("af_release",     64'(wready), 64'd1);
        writeBeat("wr3", 64'hD3, 1'b1, 64'h207, 1'b0, 64'h4F);
        checkOutput("sop_wready_idle", 64'(wready), 64'd0);

        c1rx_valid = 1'b1;
        c1rx_mdata = 16'h004F;
        applyStimulus();
        c1rx_valid = 1'b0;
        checkOutput("b_valid", 64'(bvalid), 64'd1);
        checkOutput("b_id",    64'(bid), 64'd9);
        applyStimulus();
        checkOutput("b_idle", 64'(bvalid), 64'd0);

        // Write without response: id 2, 2 lines at 0x300 -> mdata = 0x10 | 1 = 0x11
        awvalid        = 1'b1;
        awid           = 8'd2;
        awaddr         = 42'h300;
        awlen          = 2'd1;
        aw_expects_rsp = 1'b0;
        writeBeat("nr0", 64'hE0, 1'b0, 64'h300, 1'b1, 64'h11);
        writeBeat("nr1", 64'hE1, 1'b1, 64'h301, 1'b0, 64'h11);

        // Write response suppressed while a read response arrives the same cycle
        c1rx_valid  = 1'b1;
        c1rx_mdata  = 16'h0011;
        c0rx_valid  = 1'b1;
        c0rx_mdata  = 16'h0038;
        c0rx_cl_num = 2'd0;
        c0rx_data   = DATA_WIDTH'(64'h77);
        applyStimulus();
        c1rx_valid = 1'b0;
        c0rx_valid = 1'b0;
        checkOutput("nr_bvalid", 64'(bvalid), 64'd0);
        checkOutput("mix_rvalid", 64'(rvalid), 64'd1);
        checkOutput("mix_rid",    64'(rid), 64'd7);
        checkOutput("mix_rlast",  64'(rlast), 64'd1);

        // Fence: id 3 with response -> mdata = 0x18 | 4 = 0x1C
        awvalid        = 1'b1;
        awfence        = 1'b1;
        awid           = 8'd3;
        awaddr         = 42'h0;
        awlen          = 2'd0;
        aw_expects_rsp = 1'b1;
        #1;
        checkOutput("fence_wready", 64'(wready), 64'd0);
        applyStimulus();
        awvalid = 1'b0;
        awfence = 1'b0;
        checkOutput("fence_valid", 64'(c1tx_valid), 64'd1);
        checkOutput("fence_flag",  64'(c1tx_fence), 64'd1);
        checkOutput("fence_sop",   64'(c1tx_sop), 64'd1);
        checkOutput("fence_addr",  64'(c1tx_addr), 64'd0);
        checkOutput("fence_mdata", 64'(c1tx_mdata), 64'h1C);
        applyStimulus();
        checkOutput("fence_single", 64'(c1tx_valid), 64'd0);
        c1rx_valid = 1'b1;
        c1rx_mdata = 16'h001C;
        applyStimulus();
        c1rx_valid = 1'b0;
        checkOutput("fence_bvalid", 64'(bvalid), 64'd1);
        checkOutput("fence_bid",    64'(bid), 64'd3);

        // Reset in the middle of a 4-line burst: id 1 at 0x400 -> mdata = 0x08 | 4 | 3 = 0x0F
        awvalid        = 1'b1;
        awid           = 8'd1;
        awaddr         = 42'h400;
        awlen          = 2'd3;
        aw_expects_rsp = 1'b1;
        writeBeat("rb0", 64'hF0, 1'b0, 64'h400, 1'b1, 64'h0F);
        writeBeat("rb1", 64'hF1, 1'b0, 64'h401, 1'b0, 64'h0F);
        reset_n = 1'b0;
        applyStimulus();
        checkOutput("mrst_c1tx",    64'(c1tx_valid), 64'd0);
        checkOutput("mrst_awready", 64'(awready), 64'd0);
        reset_n = 1'b1;
        applyStimulus();
        checkOutput("mrst_sop", 64'(awready), 64'd1);

        // Single-line write after reset: id 6 at 0x500 -> mdata = 0x30 | 4 = 0x34
        awvalid        = 1'b1;
        awid           = 8'd6;
        awaddr         = 42'h500;
        awlen          = 2'd0;
        aw_expects_rsp = 1'b1;
        writeBeat("one", 64'hC0, 1'b1, 64'h500, 1'b1, 64'h34);
        checkOutput("one_len", 64'(c1tx_cl_len), 64'd0);
        applyStimulus();
        checkOutput("one_idle",    64'(c1tx_valid), 64'd0);
        checkOutput("one_awready", 64'(awready), 64'd1);
        c1rx_valid = 1'b1;
        c1rx_mdata = 16'h0034;
        applyStimulus();
        c1rx_valid = 1'b0;
        checkOutput("one_bvalid", 64'(bvalid), 64'd1);
        checkOutput("one_bid",    64'(bid), 64'd6);

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
        $finish;
    end

endmodule
